// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: processes DIGIT bits per cycle, LSB digit first,
// with valid/ready handshakes on the command and result sides.
module serial_addsub #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gen_param_check
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              c_q, c_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic              last_beat;
  logic [DIGIT:0]    sum;
  logic [WIDTH+DIGIT-1:0] res_cat;

  // Result may be consumed and a new command accepted on the same edge.
  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt_q == CntW'(N - 1));

  assign sum     = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  // New digit enters at the top; after N beats the LSB digit has reached bit 0.
  assign res_cat = {sum[DIGIT-1:0], res_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    c_d     = c_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StCalc;
      end
      StCalc: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = sum[DIGIT];
        res_d = res_cat[WIDTH+DIGIT-1:DIGIT];
        cnt_d = cnt_q + 1'b1;
        if (last_beat) begin
          state_d = StDone;
          carry_d = sum[DIGIT];
          ovf_d   = (sa_q == sb_q) && (res_d[WIDTH-1] != sa_q);
          zero_d  = ~|res_d;
        end
      end
      StDone: begin
        if (out_ready) state_d = in_valid ? StCalc : StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d   = a;
      b_d   = sub ? ~b : b;
      c_d   = sub;
      cnt_d = '0;
      sa_d  = a[WIDTH-1];
      sb_d  = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StCalc);
  assign result    = res_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: five instances (WIDTH/DIGIT = 6/1, 6/2, 6/3, 6/6, 8/4) checked
// against an arithmetic reference model; instance 1 (6/2) also takes the directed tests.
module tb_serial_addsub;

  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]      in_valid_s, out_ready_s, sub_s;
  logic [NI-1:0][7:0] a_s, b_s;
  wire  [NI-1:0]      in_ready_s, out_valid_s, carry_s, ovf_s, zero_s, busy_s;
  wire  [NI-1:0][7:0] res_s;

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int W = (g == 4) ? 8 : 6;
    localparam int D = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 3 : (g == 3) ? 6 : 4;
    logic [W-1:0] r;
    serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_s[g]),
      .in_ready (in_ready_s[g]),
      .a        (a_s[g][W-1:0]),
      .b        (b_s[g][W-1:0]),
      .sub      (sub_s[g]),
      .out_valid(out_valid_s[g]),
      .out_ready(out_ready_s[g]),
      .result   (r),
      .carry    (carry_s[g]),
      .overflow (ovf_s[g]),
      .zero     (zero_s[g]),
      .busy     (busy_s[g])
    );
    assign res_s[g] = 8'(r);
  end

  function automatic int cfg_w(int g);
    return (g == 4) ? 8 : 6;
  endfunction

  function automatic int cfg_d(int g);
    case (g)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return 6;
      default: return 4;
    endcase
  endfunction

  // Reference: {result[7:0], carry, overflow, zero} from plain integer arithmetic.
  function automatic logic [10:0] model(int w, int a, int b, bit sub);
    int m;
    int full, sa, sb, sr;
    logic [7:0] res;
    logic c, v, z;
    m    = 1 << w;
    full = sub ? a - b : a + b;
    c    = sub ? (a >= b) : (full >= m);
    res  = 8'(((full % m) + m) % m);
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    sr   = sub ? sa - sb : sa + sb;
    v    = (sr < -(m / 2)) || (sr >= m / 2);
    z    = (res == 8'd0);
    return {res, c, v, z};
  endfunction

  function automatic logic [10:0] observed(int g);
    return {res_s[g], carry_s[g], ovf_s[g], zero_s[g]};
  endfunction

  // Issue one command on instance g (called at a negedge, instance idle) and wait for its result.
  task automatic run_op(input int g, input int a, input int b, input bit sub,
                        output int lat, output logic [10:0] got);
    a_s[g] = 8'(a);
    b_s[g] = 8'(b);
    sub_s[g] = sub;
    in_valid_s[g] = 1'b1;
    out_ready_s[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[g] = 1'b0;
    a_s[g] = 8'($urandom);
    b_s[g] = 8'($urandom);
    sub_s[g] = 1'($urandom);
    lat = 0;
    while (!out_valid_s[g] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = observed(1) & 11'h0 | observed(g);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_s[1], out_valid_s[1], busy_s[1]} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 100", {in_ready_s[1], out_valid_s[1], busy_s[1]});
    end
    checks++;
    if (observed(1) !== 11'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 000", observed(1));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int ta[5] = '{8, 3, 31, 21, 32};
    int tb[5] = '{3, 8, 1, 21, 1};
    bit ts[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [10:0] tw[5] = '{{8'd5, 3'b100}, {8'd59, 3'b000}, {8'd32, 3'b010},
                           {8'd0, 3'b101}, {8'd31, 3'b110}};
    int lat;
    logic [10:0] got;
    for (int i = 0; i < 5; i++) begin
      run_op(1, ta[i], tb[i], ts[i], lat, got);
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d want 3", i, lat);
      end
      checks++;
      if (got !== tw[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, got, tw[i]);
      end
      checks++;
      if ({out_valid_s[1], in_ready_s[1]} !== 2'b01) begin
        errors++;
        $display("FAIL directed_idle[%0d]: got %b want 01", i, {out_valid_s[1], in_ready_s[1]});
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    a_s[1] = 8'd10;
    b_s[1] = 8'd7;
    sub_s[1] = 1'b0;
    in_valid_s[1] = 1'b1;
    out_ready_s[1] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[1] = 1'b0;
    a_s[1] = 8'($urandom);
    b_s[1] = 8'($urandom);
    lat = 0;
    while (!out_valid_s[1] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 3", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid_s[1], in_ready_s[1], observed(1)} !== {2'b10, 8'd17, 3'b000}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %b/%h want 10/%h", i,
                 {out_valid_s[1], in_ready_s[1]}, observed(1), {8'd17, 3'b000});
      end
    end
  endtask

  // Entered with instance 1 holding a result in DONE and out_ready low.
  task automatic test_back_to_back();
    int lat;
    logic [10:0] want;
    want = model(6, 5, 9, 1'b1);
    a_s[1] = 8'd5;
    b_s[1] = 8'd9;
    sub_s[1] = 1'b1;
    in_valid_s[1] = 1'b1;
    out_ready_s[1] = 1'b1;
    #1;
    checks++;
    if (in_ready_s[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready_s[1]);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid_s[1] = 1'b0;
    a_s[1] = 8'($urandom);
    b_s[1] = 8'($urandom);
    checks++;
    if ({out_valid_s[1], busy_s[1]} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_calc: got %b want 01", {out_valid_s[1], busy_s[1]});
    end
    lat = 0;
    while (!out_valid_s[1] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL b2b_latency: got %0d want 3", lat);
    end
    checks++;
    if (observed(1) !== want || want !== {8'd60, 3'b000}) begin
      errors++;
      $display("FAIL b2b_result: got %h want %h", observed(1), {8'd60, 3'b000});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    logic [10:0] got;
    logic seen;
    run_op(1, 21, 21, 1'b1, lat, got);
    a_s[1] = 8'd12;
    b_s[1] = 8'd5;
    sub_s[1] = 1'b0;
    in_valid_s[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid_s[1] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_s[1], out_valid_s[1], busy_s[1], observed(1)} !== {3'b100, 11'h0}) begin
      errors++;
      $display("FAIL rst_mid_calc: got %b/%h want 100/000",
               {in_ready_s[1], out_valid_s[1], busy_s[1]}, observed(1));
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | out_valid_s[1];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_result: got out_valid %b want 0", seen);
    end
    run_op(1, 12, 5, 1'b0, lat, got);
    checks++;
    if (lat !== 3 || got !== {8'd17, 3'b000}) begin
      errors++;
      $display("FAIL rst_fresh_op: got lat %0d %h want lat 3 %h", lat, got, {8'd17, 3'b000});
    end
  endtask

  // All instances run in lockstep; WIDTH=6 exhaustively, WIDTH=8 on 2000 random vectors.
  task automatic test_sweep();
    int va[NI], vb[NI];
    bit vs[NI];
    logic [NI-1:0] act, pend;
    logic [10:0] want;
    int k;
    for (int it = 0; it < 8192; it++) begin
      act = (it < 2000) ? 5'b11111 : 5'b01111;
      for (int g = 0; g < NI; g++) begin
        if (act[g]) begin
          if (g == 4) begin
            va[g] = int'($urandom_range(0, 255));
            vb[g] = int'($urandom_range(0, 255));
            vs[g] = 1'($urandom);
          end else begin
            va[g] = it & 63;
            vb[g] = (it >> 6) & 63;
            vs[g] = 1'((it >> 12) & 1);
          end
          a_s[g] = 8'(va[g]);
          b_s[g] = 8'(vb[g]);
          sub_s[g] = vs[g];
          in_valid_s[g] = 1'b1;
        end
      end
      out_ready_s = '1;
      @(posedge clk);
      @(negedge clk);
      in_valid_s = '0;
      for (int g = 0; g < NI; g++) begin
        a_s[g] = 8'($urandom);
        b_s[g] = 8'($urandom);
      end
      pend = act;
      k = 0;
      while (pend != '0 && k <= 20) begin
        for (int g = 0; g < NI; g++) begin
          if (pend[g] && out_valid_s[g]) begin
            pend[g] = 1'b0;
            want = model(cfg_w(g), va[g], vb[g], vs[g]);
            checks++;
            if (k !== cfg_w(g) / cfg_d(g)) begin
              errors++;
              $display("FAIL sweep_latency w%0d d%0d: got %0d want %0d", cfg_w(g), cfg_d(g),
                       k, cfg_w(g) / cfg_d(g));
            end
            checks++;
            if (observed(g) !== want) begin
              errors++;
              $display("FAIL sweep_result w%0d d%0d a=%0d b=%0d sub=%0d: got %h want %h",
                       cfg_w(g), cfg_d(g), va[g], vb[g], vs[g], observed(g), want);
            end
          end
        end
        if (pend != '0) begin
          @(negedge clk);
          k++;
        end
      end
      if (pend != '0) begin
        checks++;
        errors++;
        $display("FAIL sweep_timeout it=%0d: pending %b want 00000", it, pend);
        break;
      end
    end
  endtask

  initial begin
    in_valid_s  = '0;
    out_ready_s = '0;
    sub_s       = '0;
    a_s         = '0;
    b_s         = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
